// File: rtl/dmem_arb_pkg.sv
// Shared state/requester encodings and counter widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int LAT_CNT_W    = 3;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {REQ_CPU, REQ_DBG} req_id_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant selection between the cpu and debug requesters; cpu has priority until dbg starves.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                    cpu_req,
    input  logic                    dbg_req,
    input  logic [STARVE_CNT_W-1:0] starve_cnt,
    output logic                    gnt_valid,
    output req_id_e                 gnt_id
);

    always_comb begin
        gnt_valid = cpu_req | dbg_req;
        gnt_id    = REQ_CPU;
        if (dbg_req && (!cpu_req || starve_cnt == STARVE_CNT_W'(STARVE_MAX))) begin
            gnt_id = REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between the cpu memory stage and a debug/loader master.
// Optional `DMEM_ARB_ALIGN_CHK_EN adds cpu_err/dbg_err and rejects misaligned accesses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
`ifdef DMEM_ARB_ALIGN_CHK_EN
    output logic              cpu_err,
    output logic              dbg_err,
`endif
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy
);

    arb_state_e              state_q, state_d;
    req_id_e                 id_q, id_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [LAT_CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]       cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]       dbg_rdata_q, dbg_rdata_d;
    logic                    capture;
    logic                    gnt_valid;
    req_id_e                 gnt_id;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic                    err_q, err_d;
`endif

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .starve_cnt (starve_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign sel_we    = (gnt_id == REQ_DBG) ? dbg_we    : cpu_we;
    assign sel_addr  = (gnt_id == REQ_DBG) ? dbg_addr  : cpu_addr;
    assign sel_wdata = (gnt_id == REQ_DBG) ? dbg_wdata : cpu_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= REQ_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_cnt_q   <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_cnt_q   <= lat_cnt_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef DMEM_ARB_ALIGN_CHK_EN
            err_q       <= err_d;
`endif
        end
    end

    // Request fields are latched once in IDLE so later input changes cannot disturb the access.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_cnt_d   = lat_cnt_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        capture     = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!dbg_req) begin
                    starve_d = '0;
                end
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = ISSUE;
                    if (gnt_id == REQ_DBG) begin
                        starve_d = '0;
                    end else if (dbg_req && starve_q != STARVE_CNT_W'(STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
`ifdef DMEM_ARB_ALIGN_CHK_EN
                    err_d = (sel_addr[1:0] != 2'b00);
                    if (sel_addr[1:0] != 2'b00) begin
                        state_d = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    lat_cnt_d = LAT_CNT_W'(RD_LAT - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (capture) begin
            if (id_q == REQ_CPU) begin
                cpu_rdata_d = mem_rd_data;
            end else begin
                dbg_rdata_d = mem_rd_data;
            end
        end
    end

    // Write enable is gated by state so an async reset drops it before the commit edge.
    assign mem_wr_en   = (state_q == ISSUE) && we_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign cpu_ack     = (state_q == RESP) && (id_q == REQ_CPU);
    assign dbg_ack     = (state_q == RESP) && (id_q == REQ_DBG);
    assign cpu_rdata   = cpu_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign cpu_stall   = cpu_req & ~cpu_ack;
    assign busy        = (state_q != IDLE);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign cpu_err     = cpu_ack & err_q;
    assign dbg_err     = dbg_ack & err_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random single accesses against a transaction-level model.
// Define DMEM_ARB_ALIGN_CHK_EN for both bench and RTL to cover the misalignment response.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;
    localparam bit CPU        = 1'b0;
    localparam bit DBG        = 1'b1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack, cpu_stall;
    logic              dbg_req = 1'b0, dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic              cpu_err, dbg_err;
`endif
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] refMem   [0:63] = '{default: '0};
    logic [31:0] dmemArr  [0:63] = '{default: '0};
    logic [31:0] addrPipe [0:3]  = '{default: '0};

    dmem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .cpu_stall   (cpu_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata),
        .dbg_ack     (dbg_ack),
`ifdef DMEM_ARB_ALIGN_CHK_EN
        .cpu_err     (cpu_err),
        .dbg_err     (dbg_err),
`endif
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural dmem: synchronous write, read data follows the address by RD_LAT cycles.
    always @(posedge clk) begin
        if (mem_wr_en) dmemArr[mem_addr[7:2]] <= mem_wr_data;
        addrPipe[0] <= mem_addr;
        for (int i = 1; i < 4; i++) addrPipe[i] <= addrPipe[i-1];
    end
    assign mem_rd_data = dmemArr[addrPipe[RD_LAT-1][7:2]];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit who, input bit we, input logic [31:0] addr, input logic [31:0] data);
        if (who == CPU) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = data;
        end
    endtask

    // After the access is latched the requester's fields are scrambled; the access must not notice.
    task automatic scramble(input bit who);
        if (who == CPU) begin
            cpu_we = ~cpu_we; cpu_addr = $urandom; cpu_wdata = $urandom;
        end else begin
            dbg_we = ~dbg_we; dbg_addr = $urandom; dbg_wdata = $urandom;
        end
    endtask

    // One access whose grant edge falls 'offset' cycles after the raising negedge.
    task automatic runTxn(input string tag, input bit who, input bit we, input logic [31:0] addr,
                          input logic [31:0] data, input int offset);
        int   issueK;
        int   ackK;
        logic ownAck, otherAck;
        issueK = offset + 1;
        ackK   = offset + 2 + (we ? 0 : RD_LAT);
        for (int k = 1; k <= ackK; k++) begin
            @(negedge clk);
            ownAck   = (who == CPU) ? cpu_ack : dbg_ack;
            otherAck = (who == CPU) ? dbg_ack : cpu_ack;
            if (who == CPU) checkOutput({tag, " stall"}, 32'(cpu_stall), 32'(k != ackK));
            if (k == issueK) begin
                checkOutput({tag, " issueWrEn"}, 32'(mem_wr_en), 32'(we));
                checkOutput({tag, " issueAddr"}, mem_addr, addr);
                if (we) checkOutput({tag, " issueData"}, mem_wr_data, data);
                scramble(who);
            end else if (k > offset) begin
                checkOutput({tag, " wrEnIdle"}, 32'(mem_wr_en), 32'd0);
            end
            if (k > offset) begin
                checkOutput({tag, " ownAck"}, 32'(ownAck), 32'(k == ackK));
                checkOutput({tag, " otherAck"}, 32'(otherAck), 32'd0);
            end
        end
        if (we) begin
            refMem[addr[7:2]] = data;
        end else begin
            checkOutput({tag, " rdata"}, (who == CPU) ? cpu_rdata : dbg_rdata, refMem[addr[7:2]]);
        end
`ifdef DMEM_ARB_ALIGN_CHK_EN
        checkOutput({tag, " err"}, 32'((who == CPU) ? cpu_err : dbg_err), 32'd0);
`endif
        if (who == CPU) cpu_req = 1'b0; else dbg_req = 1'b0;
    endtask

    initial begin
        int          nAck;
        int          lastK;
        int          starveModel;
        bit          expDbg;
        bit          rWho, rWe;
        logic [31:0] rAddr, rData;
        int          gap;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst cpuAck", 32'(cpu_ack), 32'd0);
        checkOutput("rst dbgAck", 32'(dbg_ack), 32'd0);
        checkOutput("rst wrEn", 32'(mem_wr_en), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst memAddr", mem_addr, 32'd0);
        checkOutput("rst memWdata", mem_wr_data, 32'd0);
        checkOutput("rst cpuRdata", cpu_rdata, 32'd0);
        checkOutput("rst dbgRdata", dbg_rdata, 32'd0);
        rst_n = 1'b1;

        // Directed cpu write then read of the same word
        @(negedge clk);
        applyStimulus(CPU, 1'b1, 32'h40, 32'hDEADBEEF);
        runTxn("cpuWr", CPU, 1'b1, 32'h40, 32'hDEADBEEF, 0);
        @(negedge clk);
        applyStimulus(CPU, 1'b0, 32'h40, 32'h0);
        runTxn("cpuRd", CPU, 1'b0, 32'h40, 32'h0, 0);
        checkOutput("cpuRd value", cpu_rdata, 32'hDEADBEEF);

        // Simultaneous requests: cpu first, dbg address settles while cpu is served
        @(negedge clk);
        applyStimulus(CPU, 1'b1, 32'h10, 32'h0BADF00D);
        applyStimulus(DBG, 1'b0, 32'h44, 32'h0);
        fork
            runTxn("simCpu", CPU, 1'b1, 32'h10, 32'h0BADF00D, 0);
            runTxn("simDbg", DBG, 1'b0, 32'h40, 32'h0, 3);
            begin
                @(negedge clk);
                dbg_addr = 32'h40;
            end
        join
        checkOutput("simDbg value", dbg_rdata, 32'hDEADBEEF);

        // Starvation: both held, writes only; dbg must win every (STARVE_MAX+1)th grant
        repeat (2) @(negedge clk);
        applyStimulus(CPU, 1'b1, 32'h80, 32'hC0DE0001);
        applyStimulus(DBG, 1'b1, 32'h84, 32'hC0DE0002);
        nAck = 0;
        lastK = -1;
        starveModel = 0;
        for (int k = 1; k <= 60 && nAck < 10; k++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) begin
                expDbg = (starveModel == STARVE_MAX);
                starveModel = expDbg ? 0 : starveModel + 1;
                checkOutput($sformatf("starve grant%0d", nAck), 32'({cpu_ack, dbg_ack}), expDbg ? 32'd1 : 32'd2);
                checkOutput($sformatf("starve spacing%0d", nAck), 32'(k - lastK), 32'd3);
                lastK = k;
                nAck++;
            end
        end
        checkOutput("starve ackCount", 32'(nAck), 32'd10);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        refMem[6'h20] = 32'hC0DE0001;
        refMem[6'h21] = 32'hC0DE0002;

        // Reset in the middle of a cpu read aborts it; the held request restarts afterwards
        repeat (2) @(negedge clk);
        applyStimulus(CPU, 1'b0, 32'h40, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstRd cpuAck", 32'(cpu_ack), 32'd0);
        checkOutput("rstRd busy", 32'(busy), 32'd0);
        checkOutput("rstRd wrEn", 32'(mem_wr_en), 32'd0);
        checkOutput("rstRd stall", 32'(cpu_stall), 32'd1);
        checkOutput("rstRd cpuRdata", cpu_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runTxn("rstRestart", CPU, 1'b0, 32'h40, 32'h0, 0);

        // Reset during a write's ISSUE cycle must not commit it
        @(negedge clk);
        applyStimulus(DBG, 1'b1, 32'h40, 32'h12345678);
        @(negedge clk);
        checkOutput("rstWr issueWrEn", 32'(mem_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstWr wrEnDrop", 32'(mem_wr_en), 32'd0);
        dbg_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(CPU, 1'b0, 32'h40, 32'h0);
        runTxn("rstWrCheck", CPU, 1'b0, 32'h40, 32'h0, 0);

`ifdef DMEM_ARB_ALIGN_CHK_EN
        // Misaligned dbg write is answered with ack+err the cycle after grant, memory untouched
        @(negedge clk);
        applyStimulus(DBG, 1'b1, 32'h42, 32'hBADC0FFE);
        @(negedge clk);
        checkOutput("mis dbgAck", 32'(dbg_ack), 32'd1);
        checkOutput("mis dbgErr", 32'(dbg_err), 32'd1);
        checkOutput("mis cpuErr", 32'(cpu_err), 32'd0);
        checkOutput("mis wrEn", 32'(mem_wr_en), 32'd0);
        dbg_req = 1'b0;
        @(negedge clk);
        checkOutput("mis ackDrop", 32'(dbg_ack), 32'd0);
        checkOutput("mis wrEnAfter", 32'(mem_wr_en), 32'd0);
        applyStimulus(CPU, 1'b0, 32'h40, 32'h0);
        runTxn("misCheck", CPU, 1'b0, 32'h40, 32'h0, 0);
`endif

        // Random single-requester accesses
        for (int t = 0; t < 30; t++) begin
            rWho  = 1'($urandom_range(0, 1));
            rWe   = 1'($urandom_range(0, 1));
            rAddr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            rData = $urandom;
            gap   = $urandom_range(0, 2);
            @(negedge clk);
            repeat (gap) @(negedge clk);
            applyStimulus(rWho, rWe, rAddr, rData);
            runTxn($sformatf("rnd%0d", t), rWho, rWe, rAddr, rData, 0);
        end

        repeat (2) @(negedge clk);
        $display("[TB] directed and random sequences complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
